// File: rtl/fetch_unit_pkg.sv
// Shared widths, stall encodings and helpers for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int          STALL_W      = 6;
   localparam int          STALL_IF     = 0;
   localparam int          STALL_ID     = 1;
   localparam logic        STOP         = 1'b1;
   localparam logic        NO_STOP      = 1'b0;
   localparam int          IF_TO_ID_WD  = 33;
   localparam int          BR_WD        = 33;
   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

   typedef struct packed {
      logic        br_e;
      logic [31:0] br_addr;
   } br_bus_t;

   // Observation-only view of the stage; HOLD and REDIR can be true together.
   typedef enum logic [1:0] {
      FV_RUN   = 2'b00,
      FV_HOLD  = 2'b01,
      FV_REDIR = 2'b10,
      FV_BOTH  = 2'b11
   } fetch_view_e;

   // Redirect priority: flush, then a latched branch, then a live branch.
   function automatic logic [31:0] pc_select(
      input logic        flush,
      input logic [31:0] new_pc,
      input logic        br_pend,
      input logic [31:0] br_tgt,
      input logic        br_e,
      input logic [31:0] br_addr,
      input logic [31:0] pc
   );
      if (flush)        return new_pc;
      else if (br_pend) return br_tgt;
      else if (br_e)    return br_addr;
      else              return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, branch redirect latch across IF stalls,
// and an instruction hold buffer that keeps id_inst stable across ID stalls.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [31:0]            new_pc,
   input  logic [STALL_W-1:0]     stall,
   input  logic [BR_WD-1:0]       br_bus,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_wen,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata,
   input  logic [31:0]            inst_sram_rdata,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic [31:0]            id_inst
);

   logic [31:0] pc;
   logic        ce;
   logic [31:0] hold_inst;
   logic        hold_valid;
   logic        br_pend;
   logic [31:0] br_tgt;

   br_bus_t     br;
   logic        fetch_go;
   logic        id_stop;
   logic [31:0] next_pc;
   logic        stall_unused;

   assign br           = br_bus;
   assign fetch_go     = flush | (stall[STALL_IF] == NO_STOP);
   assign id_stop      = (stall[STALL_ID] == STOP);
   assign stall_unused = ^stall[STALL_W-1:2];

   always_comb begin
      next_pc = pc_select(flush, new_pc, br_pend, br_tgt, br.br_e, br.br_addr, pc);
   end

   // A branch seen while IF is frozen is latched so it is not lost; the
   // first one wins until it is consumed or a flush overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC - 32'd4;
         ce      <= 1'b0;
         br_pend <= 1'b0;
         br_tgt  <= 32'd0;
      end else begin
         if (fetch_go) begin
            pc <= next_pc;
            ce <= 1'b1;
         end
         if (fetch_go) begin
            br_pend <= 1'b0;
         end else if (br.br_e && !br_pend) begin
            br_pend <= 1'b1;
            br_tgt  <= br.br_addr;
         end
      end
   end

   // SRAM data is only valid for one cycle, so capture it on the first
   // stalled ID edge and replay it until ID moves again.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_inst  <= 32'd0;
      end else if (flush || !id_stop) begin
         hold_valid <= 1'b0;
      end else if (!hold_valid) begin
         hold_valid <= 1'b1;
         hold_inst  <= inst_sram_rdata;
      end
   end

   assign inst_sram_en    = ce & ~rst;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = pc;
   assign inst_sram_wdata = 32'd0;
   assign if_to_id_bus    = {inst_sram_en, pc};
   assign id_inst         = hold_valid ? hold_inst : inst_sram_rdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] new_pc;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic [32:0] if_to_id_bus;
   logic [31:0] id_inst;

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
      .br_bus(br_bus), .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata), .if_to_id_bus(if_to_id_bus), .id_inst(id_inst)
   );

   always #5 clk = ~clk;

   // Behavioural model: architectural state of the fetch stage.
   logic        m_known = 1'b0;
   logic [31:0] m_pc;
   logic        m_ce;
   logic        m_pend;
   logic [31:0] m_tgt;
   logic        m_hv;
   logic [31:0] m_hinst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic        go;
      logic [31:0] target;
      if (rst) begin
         m_pc = 32'hBFBF_FFFC; m_ce = 0; m_pend = 0; m_tgt = 0; m_hv = 0; m_hinst = 0;
         m_known = 1'b1;
      end else if (m_known) begin
         go = flush || !stall[0];
         if (flush)       target = new_pc;
         else if (m_pend) target = m_tgt;
         else if (br_bus[32]) target = br_bus[31:0];
         else             target = m_pc + 32'd4;
         if (go) m_pend = 0;
         else if (br_bus[32] && !m_pend) begin m_pend = 1; m_tgt = br_bus[31:0]; end
         if (go) begin m_pc = target; m_ce = 1; end
         if (flush || !stall[1]) m_hv = 0;
         else if (!m_hv) begin m_hv = 1; m_hinst = inst_sram_rdata; end
      end
   end

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_known) begin
         chk("sram_addr", 64'(inst_sram_addr), 64'(m_pc));
         chk("sram_en", 64'(inst_sram_en), 64'(m_ce & ~rst));
         chk("if_to_id_bus", 64'(if_to_id_bus), 64'({m_ce & ~rst, m_pc}));
         chk("id_inst", 64'(id_inst), 64'(m_hv ? m_hinst : inst_sram_rdata));
         chk("sram_wen_wdata", 64'({inst_sram_wen, inst_sram_wdata}), 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; flush = 0; new_pc = 0; stall = 0; br_bus = 0; inst_sram_rdata = 32'h0;

      // Reset state and first fetches.
      tick(); tick();
      chk("rst_addr", 64'(inst_sram_addr), 64'h0000_0000_BFBF_FFFC);
      chk("rst_en", 64'(inst_sram_en), 64'd0);
      chk("rst_bus", 64'(if_to_id_bus), 64'h0_BFBF_FFFC);
      rst = 0;
      tick(); chk("first_fetch", 64'(inst_sram_addr), 64'hBFC0_0000);
      chk("first_en", 64'(inst_sram_en), 64'd1);
      tick(); chk("second_fetch", 64'(inst_sram_addr), 64'hBFC0_0004);
      tick(); chk("third_fetch", 64'(inst_sram_addr), 64'hBFC0_0008);

      // Unstalled branch.
      br_bus = {1'b1, 32'hBFC0_0100};
      tick(); chk("branch_direct", 64'(inst_sram_addr), 64'hBFC0_0100);

      // Branch during IF stall is latched and taken on release.
      stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0200};
      tick(); br_bus = 0;
      tick(); tick();
      chk("stall_frozen", 64'(inst_sram_addr), 64'hBFC0_0100);
      stall = 6'b0;
      tick(); chk("pend_taken", 64'(inst_sram_addr), 64'hBFC0_0200);
      tick(); chk("pend_cleared", 64'(inst_sram_addr), 64'hBFC0_0204);

      // Hold buffer across ID stall.
      inst_sram_rdata = 32'h3402_0001;
      #1 chk("hold_pass", 64'(id_inst), 64'h3402_0001);
      stall = 6'b000010;
      tick(); inst_sram_rdata = 32'hDEAD_BEEF;
      #1 chk("hold_keep1", 64'(id_inst), 64'h3402_0001);
      tick(); chk("hold_keep2", 64'(id_inst), 64'h3402_0001);
      stall = 6'b0;
      tick(); chk("hold_release", 64'(id_inst), 64'hDEAD_BEEF);

      // Flush beats branch and both stalls.
      flush = 1; new_pc = 32'hBFC0_0380; br_bus = {1'b1, 32'hBFC0_0500}; stall = 6'b000011;
      tick(); chk("flush_pc", 64'(inst_sram_addr), 64'hBFC0_0380);
      flush = 0; br_bus = 0; stall = 0; inst_sram_rdata = 32'h1111_1111;
      #1 chk("flush_no_hold", 64'(id_inst), 64'h1111_1111);
      tick(); chk("flush_no_pend", 64'(inst_sram_addr), 64'hBFC0_0384);

      // PC wraps past the top of the address space.
      flush = 1; new_pc = 32'hFFFF_FFFC;
      tick(); flush = 0;
      chk("wrap_top", 64'(inst_sram_addr), 64'hFFFF_FFFC);
      tick(); chk("wrap_zero", 64'(inst_sram_addr), 64'h0);

      // Reset discards pending branch and held instruction.
      stall = 6'b000011; br_bus = {1'b1, 32'hBFC0_0600}; inst_sram_rdata = 32'hAAAA_5555;
      tick(); br_bus = 0; rst = 1;
      tick(); inst_sram_rdata = 32'h1234_5678;
      #1 chk("rst_addr2", 64'(inst_sram_addr), 64'hBFBF_FFFC);
      chk("rst_id_inst", 64'(id_inst), 64'h1234_5678);
      rst = 0; stall = 0;
      tick(); chk("rst_no_redirect", 64'(inst_sram_addr), 64'hBFC0_0000);
      tick(); chk("rst_seq", 64'(inst_sram_addr), 64'hBFC0_0004);

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 600; i++) begin
         rst             = ($urandom_range(0, 79) == 0);
         flush           = ($urandom_range(0, 14) == 0);
         new_pc          = $urandom & 32'hFFFF_FFFC;
         stall           = {4'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         br_bus          = {($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC};
         inst_sram_rdata = $urandom;
         tick();
      end

      rst = 0; flush = 0; stall = 0; br_bus = 0;
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
